// File: rtl/alu_pkg.sv
// Shared definitions for seq_alu: operation codes and controller states.
// Optional signed multiply/divide (MULT/DIV) is enabled by SEQ_ALU_SIGNED_EN.
package alu_pkg;

  // Single-cycle codes keep the legacy 3-bit function field, zero-extended.
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  // Iterative codes live in the upper half of the code space.
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_alu_muldiv_iter.sv
// Shared iterative datapath for seq_alu: shift-add multiply and restoring
// divide over one {hi, lo} register pair, plus the iteration counter.
// i_mode selects divide (1) or multiply (0) for both load and step.
// Operands arrive as magnitudes; any sign handling happens in seq_alu.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_next_hi,
  output logic [WIDTH-1:0] o_next_lo,
  output logic             o_last
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opd;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  // Multiply: add multiplicand when the current multiplier bit is set.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
  // Divide: shift the next dividend bit into the remainder and try a subtract.
  // The remainder is always below the divisor, so the trial fits in WIDTH+1.
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_opd};

  assign o_last = (r_cnt == CNT_W'(1));

  // Value the {hi, lo} pair takes after the current step.
  always_comb begin
    o_next_hi = w_sum[WIDTH:1];
    o_next_lo = {w_sum[0], r_lo[WIDTH-1:1]};
    if (i_mode) begin
      if (w_trial[WIDTH]) begin
        o_next_hi = w_shift[WIDTH-1:0];
        o_next_lo = {r_lo[WIDTH-2:0], 1'b0};
      end else begin
        o_next_hi = w_trial[WIDTH-1:0];
        o_next_lo = {r_lo[WIDTH-2:0], 1'b1};
      end
    end
  end

  // Operand load on acceptance, one iteration per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_opd <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_mode ? i_a : i_b;
      r_opd <= i_mode ? i_b : i_a;
      r_cnt <= CNT_W'(WIDTH);
    end else if (i_step) begin
      r_hi  <= o_next_hi;
      r_lo  <= o_next_lo;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: single-cycle AND/OR/ADD/SUB/SLT plus iterative MULTU/DIVU.
// Define SEQ_ALU_SIGNED_EN to add signed MULT/DIV (magnitude iteration with
// a sign fix-up applied as the final result is registered).
//
// Handshake: start is sampled on a rising edge only while busy=0 (states
// IDLE and FIN). A single-cycle op registers its result at that edge; an
// iterative op raises busy for WIDTH cycles. Either way done pulses for one
// cycle exactly when y/hi/zero/div_by_zero change, and those hold until the
// next done. start while busy=1 is dropped; operands need not be held.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div_by_zero,
  output logic [1:0]       o_dbg_state
);

  state_t           r_state;
  state_t           w_state_next;

  logic             r_done;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_hi;
  logic             r_zero;
  logic             r_dbz;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_iter_go;
  logic             w_single;
  logic             w_step;
  logic             w_mode;
  logic             w_last;
  logic             w_finish;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_s_y;
  logic [WIDTH-1:0] w_s_hi;
  logic             w_s_dbz;
  logic [WIDTH-1:0] w_it_hi;
  logic [WIDTH-1:0] w_it_lo;
  logic [WIDTH-1:0] w_fin_hi;
  logic [WIDTH-1:0] w_fin_lo;

  assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_FIN));
  assign w_iter_go = w_accept && (w_is_mul || (w_is_div && (b != '0)));
  assign w_single  = w_accept && !w_iter_go;
  assign w_step    = (r_state == S_MUL) || (r_state == S_DIV);
  assign w_finish  = w_step && w_last;
  // Mode follows the state while iterating, the requested op while loading.
  assign w_mode    = w_step ? (r_state == S_DIV) : w_is_div;

  assign busy        = w_step;
  assign done        = r_done;
  assign y           = r_y;
  assign hi          = r_hi;
  assign zero        = r_zero;
  assign div_by_zero = r_dbz;
  assign o_dbg_state = r_state;

`ifdef SEQ_ALU_SIGNED_EN
  logic w_sgn_op;
  logic r_sgn;
  logic r_neg_q;
  logic r_neg_r;

  assign w_sgn_op = (op == OP_MULT) || (op == OP_DIV);
  assign w_is_mul = (op == OP_MULTU) || (op == OP_MULT);
  assign w_is_div = (op == OP_DIVU) || (op == OP_DIV);
  assign w_mag_a  = (w_sgn_op && a[WIDTH-1]) ? -a : a;
  assign w_mag_b  = (w_sgn_op && b[WIDTH-1]) ? -b : b;

  // Remember result signs: product/quotient from a^b, remainder from a.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_iter_go) begin
      r_sgn   <= w_sgn_op;
      r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      r_neg_r <= a[WIDTH-1];
    end
  end

  // Sign fix-up of the final magnitude result.
  always_comb begin
    w_fin_hi = w_it_hi;
    w_fin_lo = w_it_lo;
    if (r_sgn) begin
      if (r_state == S_MUL) begin
        if (r_neg_q) {w_fin_hi, w_fin_lo} = -{w_it_hi, w_it_lo};
      end else begin
        if (r_neg_q) w_fin_lo = -w_it_lo;
        if (r_neg_r) w_fin_hi = -w_it_hi;
      end
    end
  end
`else
  assign w_is_mul = (op == OP_MULTU);
  assign w_is_div = (op == OP_DIVU);
  assign w_mag_a  = a;
  assign w_mag_b  = b;
  assign w_fin_hi = w_it_hi;
  assign w_fin_lo = w_it_lo;
`endif

  // Single-cycle results, divide-by-zero shortcut and illegal-code zeros.
  always_comb begin
    w_s_y   = '0;
    w_s_hi  = '0;
    w_s_dbz = 1'b0;
    case (op)
      OP_AND:  w_s_y = a & b;
      OP_OR:   w_s_y = a | b;
      OP_ADD:  w_s_y = a + b;
      OP_SUB:  w_s_y = a - b;
      OP_SLT:  w_s_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: begin
        if (w_is_div) begin
          w_s_y   = '1;
          w_s_hi  = a;
          w_s_dbz = 1'b1;
        end
      end
    endcase
  end

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_iter_go),
    .i_step    (w_step),
    .i_mode    (w_mode),
    .i_a       (w_mag_a),
    .i_b       (w_mag_b),
    .o_next_hi (w_it_hi),
    .o_next_lo (w_it_lo),
    .o_last    (w_last)
  );

  // Controller state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; FIN accepts a new request just like IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_FIN: begin
        if (w_iter_go) w_state_next = w_is_div ? S_DIV : S_MUL;
        else           w_state_next = S_IDLE;
      end
      S_MUL, S_DIV: begin
        if (w_last) w_state_next = S_FIN;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Result registers and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
      r_y    <= '0;
      r_hi   <= '0;
      r_zero <= 1'b1;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_single) begin
        r_done <= 1'b1;
        r_y    <= w_s_y;
        r_hi   <= w_s_hi;
        r_zero <= (w_s_y == '0);
        r_dbz  <= w_s_dbz;
      end else if (w_finish) begin
        r_done <= 1'b1;
        r_y    <= w_fin_lo;
        r_hi   <= w_fin_hi;
        r_zero <= (w_fin_lo == '0);
        r_dbz  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=32): vector table, random multiply/divide,
// mid-operation start and asynchronous reset sequences.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int EW = 2 * W + 1;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic [W-1:0] hi;
    logic         dbz;
    int           lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic [W-1:0] hi;
  logic         zero;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .y           (y),
    .hi          (hi),
    .zero        (zero),
    .div_by_zero (div_by_zero),
    .o_dbg_state (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic [W-1:0] vy, input logic [W-1:0] vh, input logic vd, input int l);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.y = vy; v.hi = vh; v.dbz = vd; v.lat = l;
    return v;
  endfunction

  // Scoreboard: compare each done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'(done), 64'd0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("y", 64'(y), 64'(e[W-1:0]));
        check("hi", 64'(hi), 64'(e[2*W-1:W]));
        check("zero", 64'(zero), 64'(e[W-1:0] == '0));
        check("div_by_zero", 64'(div_by_zero), 64'(e[EW-1]));
      end
    end
  end

  // Issue one op (called negedge-aligned), optionally poke start mid-flight.
  task automatic do_op(input vec_t v, input int poke);
    int cyc;
    int bcnt;
    exp_q.push_back({v.dbz, v.hi, v.y});
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    cyc = 0; bcnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (poke > 0 && cyc == poke) begin
        op = OP_ADD; a = 1; b = 1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end while (!done && cyc < 100);
    start = 1'b0;
    check($sformatf("latency_op%0h", v.op), 64'(cyc), 64'(v.lat));
    check($sformatf("busy_cycles_op%0h", v.op), 64'(bcnt), 64'(v.lat == 1 ? 0 : W));
  endtask

  initial begin
    int lat_it;
    lat_it = W + 1;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;

    // Vector table.
    vecs.push_back(mk(OP_ADD,   32'd5,        32'd7,        32'd12,       32'd0, 1'b0, 1));
    vecs.push_back(mk(OP_SUB,   32'd9,        32'd9,        32'd0,        32'd0, 1'b0, 1));
    vecs.push_back(mk(OP_SLT,   32'hFFFFFFFF, 32'd1,        32'd1,        32'd0, 1'b0, 1));
    vecs.push_back(mk(OP_SLT,   32'd1,        32'hFFFFFFFF, 32'd0,        32'd0, 1'b0, 1));
    vecs.push_back(mk(4'b0101,  32'd3,        32'd4,        32'd0,        32'd0, 1'b0, 1));
    vecs.push_back(mk(OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'd0, 1'b0, 1));
    vecs.push_back(mk(OP_OR,    32'h0000000F, 32'h000000F0, 32'h000000FF, 32'd0, 1'b0, 1));
    vecs.push_back(mk(OP_ADD,   32'hFFFFFFFF, 32'd1,        32'd0,        32'd0, 1'b0, 1));
    vecs.push_back(mk(OP_SUB,   32'd0,        32'd1,        32'hFFFFFFFF, 32'd0, 1'b0, 1));
    vecs.push_back(mk(OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'd1, 1'b0, lat_it));
    vecs.push_back(mk(OP_DIVU,  32'd100,      32'd7,        32'd14,       32'd2, 1'b0, lat_it));
    vecs.push_back(mk(OP_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, 32'd5, 1'b1, 1));
    vecs.push_back(mk(OP_ADD,   32'd1,        32'd1,        32'd2,        32'd0, 1'b0, 1));
    vecs.push_back(mk(OP_DIVU,  32'd3,        32'd10,       32'd0,        32'd3, 1'b0, lat_it));
`ifdef SEQ_ALU_SIGNED_EN
    vecs.push_back(mk(OP_MULT,  32'hFFFFFFFD, 32'd4,        32'hFFFFFFF4, 32'hFFFFFFFF, 1'b0, lat_it));
    vecs.push_back(mk(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, lat_it));
    vecs.push_back(mk(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, lat_it));
    vecs.push_back(mk(OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1));
`else
    vecs.push_back(mk(OP_MULT,  32'hFFFFFFFD, 32'd4,        32'd0,        32'd0, 1'b0, 1));
    vecs.push_back(mk(OP_DIV,   32'd7,        32'd2,        32'd0,        32'd0, 1'b0, 1));
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table, issued back to back (iterative ops are followed by a start in FIN).
    for (int i = 0; i < vecs.size(); i++) do_op(vecs[i], 0);

    // Results hold between done pulses.
    repeat (3) @(negedge clk);
    check("hold_y", 64'(y), 64'(vecs[vecs.size()-1].y));
    check("hold_done", 64'(done), 64'd0);

    // start during MULTU is ignored (a spurious done would be flagged).
    do_op(mk(OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd1, 1'b0, lat_it), 5);

    // Random unsigned multiply/divide against a behavioural model.
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] ra, rb;
      logic [2*W-1:0] p;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      if (i[0]) begin
        p = 64'(ra) * 64'(rb);
        do_op(mk(OP_MULTU, ra, rb, p[W-1:0], p[2*W-1:W], 1'b0, lat_it), 0);
      end else if (rb == '0) begin
        do_op(mk(OP_DIVU, ra, rb, '1, ra, 1'b1, 1), 0);
      end else begin
        do_op(mk(OP_DIVU, ra, rb, ra / rb, ra % rb, 1'b0, lat_it), 0);
      end
    end

    // Asynchronous reset in the middle of a multiply.
    do_op(mk(OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1), 0);
    op = OP_MULTU; a = 32'h12345678; b = 32'h9ABCDEF0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_y", 64'(y), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_zero", 64'(zero), 64'd1);
    check("arst_dbz", 64'(div_by_zero), 64'd0);
    check("arst_state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(mk(OP_ADD, 32'd1, 32'd1, 32'd2, 32'd0, 1'b0, 1), 0);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised next-generation ALU for the MIPS datapath.
- Keeps single-cycle AND/OR/ADD/SUB/SLT under the existing 3-bit function encoding, zero-extended to 4 bits.
- Adds iterative unsigned multiply and divide that return HI/LO results.
- Uses a start/busy/done handshake so the multi-cycle controller can stall on long operations.

Parameters:
- WIDTH, 32, operand and result width in bits; must be at least 4.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in  4  operation code (encodings under Behaviour).
- a  in  WIDTH  operand A (dividend / multiplicand).
- b  in  WIDTH  operand B (divisor / multiplier).
- busy  out  1  high while an iterative operation is in flight.
- done  out  1  one-cycle pulse when y/hi/zero are updated.
- y  out  WIDTH  result: logic/arith result, product low half, or quotient.
- hi  out  WIDTH  product high half or remainder; 0 for single-cycle ops.
- zero  out  1  (y == 0), registered together with y.
- div_by_zero  out  1  set on a divide with b==0; cleared by the next done.

Behaviour:
- Op encodings:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, y = {0..,1} or 0).
  - 1000 MULTU, 1010 DIVU.
  - All other codes are illegal: y=0, hi=0, zero=1, done after 1 cycle.
- Reset (asynchronous, any time, including mid-operation):
  - FSM goes to IDLE.
  - busy=0, done=0, y=0, hi=0, zero=1, div_by_zero=0.
  - Counter and internal shift registers are cleared.
- FSM states are IDLE, MUL, DIV and FIN.
- IDLE:
  - start=1 with a single-cycle/illegal op: result registered at that edge; done=1 in the following cycle; stay in IDLE.
  - start=1 with MULTU: load operands, count=WIDTH, go to MUL; busy=1 from the next cycle.
  - start=1 with DIVU and b!=0: same as MULTU, going to DIV.
  - start=1 with DIVU and b==0: complete in 1 cycle with y=all ones, hi=a, div_by_zero=1.
- MUL: shift-add, one multiplier bit per cycle, producing a 2*WIDTH-bit product; count decrements; at count==1, go to FIN.
- DIV: restoring division, one quotient bit per cycle; at count==1, go to FIN.
- FIN: register y/hi/zero, done=1, busy=0, return to IDLE. start is accepted in FIN (back-to-back).
- Latency:
  - Single-cycle ops: done one cycle after the accepting edge.
  - MULTU/DIVU: done WIDTH+1 cycles after the accepting edge.
- start while busy=1 is ignored; operands need not be held after acceptance.
- ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
- y/hi/zero hold their value between done pulses.

Optional Feature:
- Macro: SEQ_ALU_SIGNED_EN.
- When defined: op 1001 MULT and op 1011 DIV (two's-complement).
  - Implemented as magnitude iteration plus sign fix-up in FIN; same latency.
  - Remainder takes the sign of the dividend; quotient truncates toward zero.
  - Signed divide by zero gives y=all ones, hi=a, div_by_zero=1.
  - MIN/-1 gives y=MIN, hi=0.
- When undefined: 1001 and 1011 are illegal codes (y=0, hi=0, 1 cycle); no sign logic is synthesised.

Decomposition:
- Package alu_pkg:
  - op code localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MULTU, OP_MULT, OP_DIVU, OP_DIV).
  - FSM state enum (S_IDLE, S_MUL, S_DIV, S_FIN).
- One sub-module, muldiv_iter:
  - Holds the shared shift/accumulate datapath and the counter.
  - Controlled by a mode bit from the seq_alu FSM.
  - Single-cycle ops stay in seq_alu.

Test Plan (WIDTH=32):
- ADD a=5, b=7 -> y=12, hi=0, zero=0, done one cycle after start. SUB a=9, b=9 -> y=0, zero=1.
- SLT a=0xFFFFFFFF, b=1 -> y=1. SLT a=1, b=0xFFFFFFFF -> y=0. op=0101 -> y=0, zero=1, done after 1 cycle.
- MULTU a=0xFFFFFFFF, b=2 -> hi=1, y=0xFFFFFFFE, busy high 32 cycles, done at cycle 33. start pulsed mid-operation is ignored.
- DIVU a=100, b=7 -> y=14, hi=2, done at cycle 33. DIVU a=5, b=0 -> y=0xFFFFFFFF, hi=5, div_by_zero=1, done at cycle 1.
- Reset asserted asynchronously at cycle 10 of MULTU -> immediately busy=0, y=0, hi=0, zero=1. A following ADD 1+1 gives y=2 normally.
- With SEQ_ALU_SIGNED_EN: MULT -3*4 -> hi=0xFFFFFFFF, y=0xFFFFFFF4. DIV -7/2 -> y=0xFFFFFFFD, hi=0xFFFFFFFF. Without the macro, op 1001 -> y=0 after 1 cycle.
